// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller:
// FSM states, ALU operations, data-processing commands, condition codes and mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWRITE,
        MEMWB,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the instruction register / ALU and the controller.
// The master side is the controller; the slave side is the datapath.
interface multicycle_controller_if #(parameter int ALUCTRL_W = 3);

    logic [31:12]          Instr;
    logic [3:0]            ALUFlags;
    logic                  PCWrite;
    logic                  AdrSrc;
    logic                  MemWrite;
    logic                  IRWrite;
    logic [1:0]            ResultSrc;
    logic                  ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [1:0]            RegSrc;
    logic                  RegWrite;
    logic [1:0]            ImmSrc;
    logic [ALUCTRL_W-1:0]  ALUControl;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, RegSrc, RegWrite, ImmSrc, ALUControl
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, RegSrc, RegWrite, ImmSrc, ALUControl
    );

endinterface

// File: rtl/multicycle_controller_cond_unit.sv
// Flags register, condition evaluation and the registered condition-pass bit
// that gates every architectural write of the current instruction.
module cond_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] aluFlags,
    input  logic [1:0] flagW,
    input  logic       condLoad,
    input  logic       flagLoad,
    output logic       condEx
);

    logic [3:0] flags;
    logic       condMet;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags;

    // Condition evaluation against the architectural flags
    always_comb begin
        condMet = 1'b0;
        case (cond)
            COND_EQ: condMet = z;
            COND_NE: condMet = ~z;
            COND_CS: condMet = c;
            COND_CC: condMet = ~c;
            COND_MI: condMet = n;
            COND_PL: condMet = ~n;
            COND_VS: condMet = v;
            COND_VC: condMet = ~v;
            COND_HI: condMet = c & ~z;
            COND_LS: condMet = ~c | z;
            COND_GE: condMet = (n == v);
            COND_LT: condMet = (n != v);
            COND_GT: condMet = ~z & (n == v);
            COND_LE: condMet = z | (n != v);
            COND_AL: condMet = 1'b1;
            default: condMet = 1'b0;
        endcase
    end

    // NZ and CV halves update independently, and only for instructions that passed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (flagLoad && condEx) begin
            if (flagW[1]) flags[3:2] <= aluFlags[3:2];
            if (flagW[0]) flags[1:0] <= aluFlags[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            condEx <= 1'b0;
        end else if (condLoad) begin
            condEx <= condMet;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for the multicycle ARM-subset datapath: sequences each
// instruction over 2-5 cycles and drives every mux select and write enable.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int EXT_OPS   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    state_t     state, nextState;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       sBit;
    logic       rdIsPc;
    logic [2:0] aluOp;
    logic       noWrite;
    logic [1:0] flagW;
    logic       condEx;
    logic       unusedRn;

    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, aluSrcA;
    logic [1:0] resultSrc, aluSrcB;
    logic [2:0] aluCtrl;

    assign op       = bus.Instr[27:26];
    assign funct    = bus.Instr[25:20];
    assign cmd      = funct[4:1];
    assign sBit     = funct[0];
    assign rdIsPc   = (bus.Instr[15:12] == 4'hF);
    assign unusedRn = ^bus.Instr[19:16];

    // Data-processing decode; unknown commands behave as a flagless, writeless ADD
    always_comb begin
        aluOp   = ALU_ADD;
        noWrite = 1'b1;
        flagW   = 2'b00;
        case (cmd)
            CMD_ADD: begin aluOp = ALU_ADD; noWrite = 1'b0; flagW = {sBit, sBit}; end
            CMD_SUB: begin aluOp = ALU_SUB; noWrite = 1'b0; flagW = {sBit, sBit}; end
            CMD_AND: begin aluOp = ALU_AND; noWrite = 1'b0; flagW = {sBit, 1'b0}; end
            CMD_ORR: begin aluOp = ALU_ORR; noWrite = 1'b0; flagW = {sBit, 1'b0}; end
            CMD_EOR: if (EXT_OPS != 0) begin aluOp = ALU_EOR; noWrite = 1'b0; flagW = {sBit, 1'b0}; end
            CMD_CMP: if (EXT_OPS != 0) begin aluOp = ALU_SUB; flagW = 2'b11; end
            CMD_TST: if (EXT_OPS != 0) begin aluOp = ALU_AND; flagW = 2'b10; end
            default: ;
        endcase
    end

    cond_unit u_cond (
        .clk      (clk),
        .reset    (reset),
        .cond     (bus.Instr[31:28]),
        .aluFlags (bus.ALUFlags),
        .flagW    (flagW),
        .condLoad (state == DECODE),
        .flagLoad ((state == EXECUTER) || (state == EXECUTEI)),
        .condEx   (condEx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= nextState;
    end

    // Next state and Moore outputs; every output defaults to 0
    always_comb begin
        nextState = FETCH;
        pcWrite   = 1'b0;
        adrSrc    = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        regWrite  = 1'b0;
        aluSrcA   = 1'b0;
        resultSrc = RES_ALUOUT;
        aluSrcB   = SRCB_REG;
        aluCtrl   = ALU_ADD;
        case (state)
            FETCH: begin
                nextState = DECODE;
                irWrite   = 1'b1;
                pcWrite   = 1'b1;
                aluSrcA   = 1'b1;
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALU;
            end
            DECODE: begin
                aluSrcA   = 1'b1;
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALU;
                case (op)
                    2'b00:   nextState = funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   nextState = MEMADR;
                    2'b10:   nextState = BRANCH;
                    default: nextState = FETCH;
                endcase
            end
            MEMADR: begin
                nextState = funct[0] ? MEMREAD : MEMWRITE;
                aluSrcB   = SRCB_IMM;
            end
            MEMREAD: begin
                nextState = MEMWB;
                adrSrc    = 1'b1;
            end
            MEMWRITE: begin
                adrSrc    = 1'b1;
                memWrite  = condEx;
            end
            MEMWB: begin
                resultSrc = RES_DATA;
                regWrite  = condEx;
                pcWrite   = condEx & rdIsPc;
            end
            EXECUTER: begin
                nextState = ALUWB;
                aluCtrl   = aluOp;
            end
            EXECUTEI: begin
                nextState = ALUWB;
                aluSrcB   = SRCB_IMM;
                aluCtrl   = aluOp;
            end
            ALUWB: begin
                regWrite  = condEx & ~noWrite;
                pcWrite   = condEx & ~noWrite & rdIsPc;
            end
            BRANCH: begin
                aluSrcB   = SRCB_IMM;
                resultSrc = RES_ALU;
                pcWrite   = condEx;
            end
            default: ;
        endcase
    end

    // Write enables are killed combinationally so reset aborts any write at once
    assign bus.PCWrite    = pcWrite  & ~reset;
    assign bus.IRWrite    = irWrite  & ~reset;
    assign bus.RegWrite   = regWrite & ~reset;
    assign bus.MemWrite   = memWrite & ~reset;
    assign bus.AdrSrc     = adrSrc;
    assign bus.ResultSrc  = resultSrc;
    assign bus.ALUSrcA    = aluSrcA;
    assign bus.ALUSrcB    = aluSrcB;
    assign bus.ALUControl = ALUCTRL_W'(aluCtrl);
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {op == 2'b01, op == 2'b10};

endmodule
